// File: rtl/calcsys_control_unit.sv
// Sequencing FSM for the calculator datapath (Moore outputs).
// Optional build macro: CALC_TIMEOUT_EN enables the CWAIT/DWAIT abort.
module calcsys_control_unit #(
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [2:0] OP_out,
    input  logic       errFlag,
    input  logic       done_calc,
    input  logic       done_div,
    output logic       x_en,
    output logic       y_en,
    output logic       f_en,
    output logic       hi_en,
    output logic       lo_en,
    output logic [1:0] sel_lo,
    output logic [1:0] sel_hi,
    output logic       sel_p,
    output logic [1:0] op_calc,
    output logic       go_calc,
    output logic       go_div,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] CS
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD   = 4'd1,
        S_DECODE = 4'd2,
        S_PASS   = 4'd3,
        S_CALC   = 4'd4,
        S_CWAIT  = 4'd5,
        S_MUL    = 4'd6,
        S_DIV    = 4'd7,
        S_DWAIT  = 4'd8,
        S_WRITE  = 4'd9,
        S_DONE   = 4'd10,
        S_ERR    = 4'd11
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic       go_q;
    logic       go_rise;
    logic [3:0] mul_cnt;
    logic [7:0] wait_cnt;
    logic       mul_last;
    logic       wait_last;
    logic [1:0] sel_r;
    logic       sel_p_r;
    logic [1:0] op_r;

    assign go_rise   = go & ~go_q;
    assign mul_last  = (mul_cnt == 4'(MUL_LAT - 1));
    assign wait_last = (wait_cnt == 8'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // Go edge history is tracked every cycle so a held level never restarts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) go_q <= 1'b0;
        else      go_q <= go;
    end

    // Multiplier latency counter, active only while in MUL
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 mul_cnt <= '0;
        else if (state == S_MUL)  mul_cnt <= mul_cnt + 4'd1;
        else                      mul_cnt <= '0;
    end

    // Wait-cycle counter for CWAIT/DWAIT; saturates at the last cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (state == S_CWAIT || state == S_DWAIT) begin
            if (!wait_last) wait_cnt <= wait_cnt + 8'd1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Result routing captured in DECODE and held through WRITE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_r   <= 2'b00;
            sel_p_r <= 1'b0;
            op_r    <= 2'b00;
        end else if (state == S_DECODE) begin
            case (OP_out)
                3'b000:  begin sel_r <= 2'b00; sel_p_r <= 1'b0; end
                3'b001:  begin sel_r <= 2'b00; sel_p_r <= 1'b1; end
                3'b010:  begin sel_r <= 2'b01; op_r <= 2'b00; end
                3'b011:  begin sel_r <= 2'b01; op_r <= 2'b01; end
                3'b100:  begin sel_r <= 2'b01; op_r <= 2'b10; end
                3'b101:  begin sel_r <= 2'b01; op_r <= 2'b11; end
                3'b110:  sel_r <= 2'b10;
                default: sel_r <= 2'b11;
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (go_rise) state_nx = S_LOAD;
            S_LOAD:   state_nx = errFlag ? S_ERR : S_DECODE;
            S_DECODE: begin
                case (OP_out)
                    3'b000, 3'b001: state_nx = S_PASS;
                    3'b110:         state_nx = S_MUL;
                    3'b111:         state_nx = S_DIV;
                    default:        state_nx = S_CALC;
                endcase
            end
            S_PASS:   state_nx = S_WRITE;
            S_CALC:   state_nx = S_CWAIT;
            S_CWAIT: begin
                if (done_calc) state_nx = S_WRITE;
`ifdef CALC_TIMEOUT_EN
                else if (wait_last) state_nx = S_ERR;
`endif
            end
            S_MUL:    if (mul_last) state_nx = S_WRITE;
            S_DIV:    state_nx = S_DWAIT;
            S_DWAIT: begin
                if (done_div) state_nx = S_WRITE;
`ifdef CALC_TIMEOUT_EN
                else if (wait_last) state_nx = S_ERR;
`endif
            end
            S_WRITE:  state_nx = S_DONE;
            S_DONE:   state_nx = S_IDLE;
            S_ERR:    if (go_rise) state_nx = S_LOAD;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state
    always_comb begin
        x_en    = 1'b0;
        y_en    = 1'b0;
        f_en    = 1'b0;
        hi_en   = 1'b0;
        lo_en   = 1'b0;
        go_calc = 1'b0;
        go_div  = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        err     = 1'b0;
        case (state)
            S_IDLE:  busy = 1'b0;
            S_LOAD:  begin x_en = 1'b1; y_en = 1'b1; f_en = 1'b1; end
            S_CALC:  go_calc = 1'b1;
            S_DIV:   go_div = 1'b1;
            S_WRITE: begin hi_en = 1'b1; lo_en = 1'b1; end
            S_DONE:  begin busy = 1'b0; done = 1'b1; end
            S_ERR:   begin busy = 1'b0; err = 1'b1; end
            default: ;
        endcase
    end

    assign sel_lo  = sel_r;
    assign sel_hi  = sel_r;
    assign sel_p   = sel_p_r;
    assign op_calc = op_r;
    assign CS      = state;

endmodule

// File: tb/tb_calcsys_control_unit.sv
// Directed bench for calcsys_control_unit.
// Expected values are hand-derived from the state sequence.
module tb_calcsys_control_unit;

    logic       clk;
    logic       rst;
    logic       go;
    logic [2:0] OP_out;
    logic       errFlag;
    logic       done_calc;
    logic       done_div;
    logic       x_en, y_en, f_en, hi_en, lo_en;
    logic [1:0] sel_lo, sel_hi;
    logic       sel_p;
    logic [1:0] op_calc;
    logic       go_calc, go_div, busy, done, err;
    logic [3:0] CS;

    int errors = 0;
    int checks = 0;

    calcsys_control_unit #(.MUL_LAT(3), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .go(go), .OP_out(OP_out),
        .errFlag(errFlag), .done_calc(done_calc), .done_div(done_div),
        .x_en(x_en), .y_en(y_en), .f_en(f_en),
        .hi_en(hi_en), .lo_en(lo_en),
        .sel_lo(sel_lo), .sel_hi(sel_hi), .sel_p(sel_p),
        .op_calc(op_calc), .go_calc(go_calc), .go_div(go_div),
        .busy(busy), .done(done), .err(err), .CS(CS)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All outputs packed: x y f hi lo sel_lo sel_hi sel_p op_calc gc gd busy done err CS
    logic [20:0] outs;
    assign outs = {x_en, y_en, f_en, hi_en, lo_en, sel_lo, sel_hi, sel_p,
                   op_calc, go_calc, go_div, busy, done, err, CS};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; go = 1'b0; OP_out = 3'b000;
        errFlag = 1'b0; done_calc = 1'b0; done_div = 1'b0;
        step(); step();
        chk("reset_outs", 32'(outs), 32'h0);
        rst = 1'b1;
        step();
        chk("idle_after_rst", 32'(CS), 32'd0);

        // 1: ADD
        OP_out = 3'b010; go = 1'b1;
        step();
        chk("add_load_cs", 32'(CS), 32'd1);
        chk("add_load_en", 32'({x_en, y_en, f_en, busy}), 32'hF);
        step();
        chk("add_decode", 32'({CS, x_en}), 32'({4'd2, 1'b0}));
        step();
        chk("add_calc", 32'({CS, go_calc, op_calc, sel_lo, sel_hi}),
            32'({4'd4, 1'b1, 2'b00, 2'b01, 2'b01}));
        step();
        chk("add_cwait", 32'({CS, go_calc}), 32'({4'd5, 1'b0}));
        step(); step();
        chk("add_cwait_hold", 32'(CS), 32'd5);
        done_calc = 1'b1;
        step();
        done_calc = 1'b0;
        chk("add_write", 32'({CS, hi_en, lo_en, sel_lo, sel_hi}),
            32'({4'd9, 1'b1, 1'b1, 2'b01, 2'b01}));
        step();
        chk("add_done", 32'({CS, done, busy, hi_en}),
            32'({4'd10, 1'b1, 1'b0, 1'b0}));
        step();
        chk("add_idle", 32'({CS, done}), 32'({4'd0, 1'b0}));
        step(); step();
        chk("add_go_held", 32'(CS), 32'd0);

        // 2: MUL
        OP_out = 3'b110; go = 1'b0;
        step();
        go = 1'b1;
        step();
        chk("mul_load", 32'(CS), 32'd1);
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mul_state", 32'({CS, go_calc, go_div}),
                32'({4'd6, 1'b0, 1'b0}));
        end
        step();
        chk("mul_write", 32'({CS, hi_en, sel_lo, sel_hi}),
            32'({4'd9, 1'b1, 2'b10, 2'b10}));
        step(); step();
        chk("mul_idle", 32'(CS), 32'd0);

        // 3: DIV by zero
        OP_out = 3'b111; errFlag = 1'b1; go = 1'b0;
        step();
        go = 1'b1;
        step();
        chk("div0_load", 32'(CS), 32'd1);
        step();
        chk("div0_err", 32'({CS, err, busy, go_div, hi_en, lo_en}),
            32'({4'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
        step(); step();
        chk("div0_err_hold", 32'({CS, err, go_div}), 32'({4'd11, 1'b1, 1'b0}));
        go = 1'b0; errFlag = 1'b0;
        step();
        chk("div0_err_go_low", 32'(CS), 32'd11);
        go = 1'b1;
        step();
        chk("err_to_load", 32'({CS, err}), 32'({4'd1, 1'b0}));
        step();
        done_div = 1'b1;
        step();
        chk("div_state", 32'({CS, go_div, sel_lo, sel_hi}),
            32'({4'd7, 1'b1, 2'b11, 2'b11}));
        step();
        done_div = 1'b0;
        chk("div_dwait", 32'({CS, go_div}), 32'({4'd8, 1'b0}));
        step();
        chk("div_done_ignored", 32'(CS), 32'd8);

        // 4: async reset mid-DWAIT
        #3 rst = 1'b0;
        #1 chk("async_rst_outs", 32'(outs), 32'h0);
        go = 1'b0;
        step();
        rst = 1'b1;
        step(); step();
        chk("post_rst_idle", 32'(CS), 32'd0);

        // 5: CWAIT with done_calc low
        OP_out = 3'b101; go = 1'b1;
        step();
        chk("or_load", 32'(CS), 32'd1);
        step(); step();
        chk("or_calc", 32'({CS, op_calc}), 32'({4'd4, 2'b11}));
        step();
        chk("or_cwait", 32'(CS), 32'd5);
        for (int i = 1; i < 15; i++) step();
        chk("cwait_14", 32'(CS), 32'd5);
        step();
`ifdef CALC_TIMEOUT_EN
        chk("timeout_err", 32'({CS, err, hi_en}), 32'({4'd11, 1'b1, 1'b0}));
`else
        chk("no_timeout", 32'(CS), 32'd5);
        for (int i = 0; i < 10; i++) step();
        chk("no_timeout_long", 32'(CS), 32'd5);
`endif
        rst = 1'b0; go = 1'b0;
        step();
        rst = 1'b1;
        step();

        // 6: PASS Y with go held through DONE
        OP_out = 3'b001; go = 1'b1;
        step(); step(); step();
        chk("pass_state", 32'({CS, sel_p, sel_lo, sel_hi}),
            32'({4'd3, 1'b1, 2'b00, 2'b00}));
        step();
        chk("pass_write", 32'({CS, hi_en, lo_en}), 32'({4'd9, 1'b1, 1'b1}));
        step();
        chk("pass_done", 32'({CS, done}), 32'({4'd10, 1'b1}));
        step(); step(); step();
        chk("held_go_idle", 32'({CS, busy}), 32'({4'd0, 1'b0}));
        go = 1'b0;
        step();
        chk("go_low_idle", 32'(CS), 32'd0);
        go = 1'b1;
        step();
        chk("go_rerise_load", 32'(CS), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
